// File: rtl/aux_cmd_engine.sv
// aux_cmd_engine: packetised register-access command processor over the aux pipes.
// Pulls command words from the aux block, drives the register bus, and pushes responses back.
module aux_cmd_engine #(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              aux_read_req,
    output logic              aux_write_req,
    output logic [31:0]       aux_data_write,
    input  logic [31:0]       aux_data_read,
    output logic [16:0]       aux_address,
    input  logic              aux_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [31:0]       reg_rdata,
    output logic [15:0]       cmd_count,
    output logic [7:0]        err_count
);
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    typedef enum logic [3:0] {
        IDLE, GET_HDR, PARSE, GET_DATA, REG_WR, PUT_ACK, PUT_ERR,
        PUT_HDR, REG_RD, RD_WAIT, PUT_DATA, DONE
    } state_t;

    // Each aux transfer is req pulse -> busy rises -> busy falls.
    typedef enum logic [1:0] {AX_REQ, AX_WAIT_HI, AX_WAIT_LO} ax_phase_t;

    state_t      state, state_next;
    ax_phase_t   ax_phase, ax_phase_next;
    logic [31:0] hdr_q, hdr_next;
    logic [31:0] data_q, data_next;
    logic [7:0]  idx_q, idx_next;
    logic [3:0]  wait_q, wait_next;

    logic              rd_req_next, wr_req_next, reg_we_next, reg_re_next;
    logic [31:0]       aux_wdata_next, reg_wdata_next;
    logic [ADDR_W-1:0] reg_addr_next;
    logic [15:0]       cmd_next;
    logic [7:0]        err_next;
    logic              ax_done;

    logic [7:0]  hdr_op, hdr_n;
    logic [15:0] hdr_base, cur_addr;
    logic        ax_read, ax_write;
    logic [31:0] tx_word;

    assign aux_address = 17'd0;
    assign hdr_op      = hdr_q[31:24];
    assign hdr_n       = hdr_q[23:16];
    assign hdr_base    = hdr_q[15:0];
    assign cur_addr    = hdr_base + {8'd0, idx_q};
    assign ax_read     = (state == GET_HDR) || (state == GET_DATA);
    assign ax_write    = (state == PUT_ACK) || (state == PUT_ERR) ||
                         (state == PUT_HDR) || (state == PUT_DATA);
    assign tx_word     = (state == PUT_ACK) ? {8'hA1, hdr_n, hdr_base} :
                         (state == PUT_HDR) ? {8'hA2, hdr_n, hdr_base} :
                         (state == PUT_ERR) ? {8'hEE, 8'h00, hdr_base} : data_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next     = state;
        ax_phase_next  = ax_phase;
        hdr_next       = hdr_q;
        data_next      = data_q;
        idx_next       = idx_q;
        wait_next      = wait_q;
        rd_req_next    = 1'b0;
        wr_req_next    = 1'b0;
        reg_we_next    = 1'b0;
        reg_re_next    = 1'b0;
        aux_wdata_next = aux_data_write;
        reg_addr_next  = reg_addr;
        reg_wdata_next = reg_wdata;
        cmd_next       = cmd_count;
        err_next       = err_count;
        ax_done        = 1'b0;

        if (ax_read || ax_write) begin
            case (ax_phase)
                AX_REQ: if (!aux_busy) begin
                    rd_req_next   = ax_read;
                    wr_req_next   = ax_write;
                    if (ax_write) aux_wdata_next = tx_word;
                    ax_phase_next = AX_WAIT_HI;
                end
                AX_WAIT_HI: if (aux_busy) ax_phase_next = AX_WAIT_LO;
                AX_WAIT_LO: if (!aux_busy) begin
                    ax_phase_next = AX_REQ;
                    ax_done       = 1'b1;
                end
                default: ax_phase_next = AX_REQ;
            endcase
        end

        case (state)
            IDLE: state_next = GET_HDR;
            GET_HDR: if (ax_done) begin
                hdr_next   = aux_data_read;
                idx_next   = 8'd0;
                state_next = PARSE;
            end
            PARSE: begin
                if (hdr_op == OP_WRITE && hdr_n != 8'd0) begin
                    state_next = GET_DATA;
                end else if (hdr_op == OP_READ && hdr_n != 8'd0) begin
                    state_next = PUT_HDR;
                end else begin
                    state_next = PUT_ERR;
                    if (err_count != 8'hFF) err_next = err_count + 8'd1;
                end
            end
            GET_DATA: if (ax_done) begin
                data_next  = aux_data_read;
                state_next = REG_WR;
            end
            REG_WR: begin
                reg_we_next    = 1'b1;
                reg_addr_next  = ADDR_W'(cur_addr);
                reg_wdata_next = data_q;
                idx_next       = idx_q + 8'd1;
                state_next     = (idx_q + 8'd1 == hdr_n) ? PUT_ACK : GET_DATA;
            end
            PUT_ACK, PUT_ERR: if (ax_done) state_next = DONE;
            PUT_HDR: if (ax_done) state_next = REG_RD;
            REG_RD: begin
                reg_re_next   = 1'b1;
                reg_addr_next = ADDR_W'(cur_addr);
                wait_next     = 4'(RD_LATENCY);
                state_next    = RD_WAIT;
            end
            // wait_q reaches zero in the cycle reg_rdata is valid for this strobe.
            RD_WAIT: begin
                if (wait_q == 4'd0) begin
                    data_next  = reg_rdata;
                    state_next = PUT_DATA;
                end else begin
                    wait_next = wait_q - 4'd1;
                end
            end
            PUT_DATA: if (ax_done) begin
                idx_next   = idx_q + 8'd1;
                state_next = (idx_q + 8'd1 == hdr_n) ? DONE : REG_RD;
            end
            DONE: begin
                cmd_next   = cmd_count + 16'd1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state          <= IDLE;
            ax_phase       <= AX_REQ;
            hdr_q          <= '0;
            data_q         <= '0;
            idx_q          <= '0;
            wait_q         <= '0;
            aux_read_req   <= 1'b0;
            aux_write_req  <= 1'b0;
            aux_data_write <= '0;
            reg_addr       <= '0;
            reg_wdata      <= '0;
            reg_we         <= 1'b0;
            reg_re         <= 1'b0;
            cmd_count      <= '0;
            err_count      <= '0;
        end else begin
            state          <= state_next;
            ax_phase       <= ax_phase_next;
            hdr_q          <= hdr_next;
            data_q         <= data_next;
            idx_q          <= idx_next;
            wait_q         <= wait_next;
            aux_read_req   <= rd_req_next;
            aux_write_req  <= wr_req_next;
            aux_data_write <= aux_wdata_next;
            reg_addr       <= reg_addr_next;
            reg_wdata      <= reg_wdata_next;
            reg_we         <= reg_we_next;
            reg_re         <= reg_re_next;
            cmd_count      <= cmd_next;
            err_count      <= err_next;
        end
    end
endmodule
